// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low segment patterns (bit0 = a .. bit6 = g)
// and the capture FSM state type, used by both the display decoder and the capture block.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

endpackage

// File: rtl/seven_seg_pattern_to_hex.sv
// Combinational inverse of the display decoder: active-low segment pattern back to a hex value.
module seven_seg_pattern_to_hex
  import seven_seg_pkg::*;
(
  input  logic [6:0] segs,
  output logic [3:0] value,
  output logic       legal,
  output logic       is_blank
);

  always_comb begin
    value = 4'h0;
    legal = 1'b1;
    case (segs)
      SEG_0:   value = 4'h0;
      SEG_1:   value = 4'h1;
      SEG_2:   value = 4'h2;
      SEG_3:   value = 4'h3;
      SEG_4:   value = 4'h4;
      SEG_5:   value = 4'h5;
      SEG_6:   value = 4'h6;
      SEG_7:   value = 4'h7;
      SEG_8:   value = 4'h8;
      SEG_9:   value = 4'h9;
      SEG_A:   value = 4'hA;
      SEG_B:   value = 4'hB;
      SEG_C:   value = 4'hC;
      SEG_D:   value = 4'hD;
      SEG_E:   value = 4'hE;
      SEG_F:   value = 4'hF;
      default: legal = 1'b0;
    endcase
    is_blank = (segs == SEG_BLANK);
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures the digit shown on each position of a multiplexed active-low seven-segment bus
// once the strobe window has held steady for STABLE_CYCLES synchronised cycles.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            segs,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     blank,
  output logic                  update,
  output logic [2:0]            update_pos,
  output logic                  bad_pattern,
  output state_t                state_dbg
);

  localparam int         SW       = DIGITS + 7;
  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  logic [SW-1:0]     sync1, sync2, s_prev;
  logic [DIGITS-1:0] an_s, lit;
  logic [6:0]        seg_s;
  logic [2:0]        pos;
  logic              one_hot, changed, settle_done, capture;
  logic [7:0]        cnt, cnt_nxt, cnt_inc;
  state_t            state, state_nxt;
  logic [3:0]        dec_value;
  logic              dec_legal, dec_blank;

  // Synchroniser idles at all-ones so reset looks like a dark, unstrobed bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {an, segs};
      sync2 <= sync1;
    end
  end

  assign an_s    = sync2[SW-1:7];
  assign seg_s   = sync2[6:0];
  assign lit     = ~an_s;
  assign changed = (sync2 != s_prev);
  assign cnt_inc = cnt + 8'd1;
  assign settle_done = (cnt_inc >= STABLE_C);

  always_comb begin
    int n_low;
    n_low = 0;
    pos   = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (lit[i]) begin
        n_low = n_low + 1;
        pos   = 3'(i);
      end
    end
    one_hot = (n_low == 1);
  end

  // State register, run counter and previous-sample copy for change detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 8'd0;
      s_prev <= '1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      s_prev <= sync2;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (changed) begin
      state_nxt = one_hot ? ST_SETTLE : ST_IDLE;
      cnt_nxt   = one_hot ? 8'd1 : 8'd0;
    end else begin
      case (state)
        ST_SETTLE: begin
          cnt_nxt = cnt_inc;
          if (settle_done) state_nxt = ST_HELD;
        end
        ST_HELD: if (cnt != 8'hFF) cnt_nxt = cnt_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    capture = (state == ST_SETTLE) && !changed && settle_done;
  end

  assign state_dbg = state;

  seven_seg_pattern_to_hex u_dec (
    .segs     (seg_s),
    .value    (dec_value),
    .legal    (dec_legal),
    .is_blank (dec_blank)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits      <= '0;
      digit_valid <= '0;
      blank       <= '0;
      update      <= 1'b0;
      update_pos  <= 3'd0;
      bad_pattern <= 1'b0;
    end else begin
      update <= capture;
      if (capture) begin
        update_pos <= pos;
        if (!dec_legal && !dec_blank) bad_pattern <= 1'b1;
      end
      for (int i = 0; i < DIGITS; i++) begin
        if (capture && lit[i]) begin
          digits[4*i +: 4] <= dec_legal ? dec_value : 4'h0;
          digit_valid[i]   <= dec_legal;
          blank[i]         <= dec_blank;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture with DIGITS=4, STABLE_CYCLES=4.
module tb_seven_seg_capture;
  import seven_seg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  segs;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  blank;
  logic        update;
  logic [2:0]  update_pos;
  logic        bad_pattern;
  state_t      state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int upd_cnt = 0;
  logic prev_upd = 1'b0;
  logic [2:0] exp_q[$];
  logic [6:0] scan_pat [4];

  seven_seg_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .segs        (segs),
    .an          (an),
    .digits      (digits),
    .digit_valid (digit_valid),
    .blank       (blank),
    .update      (update),
    .update_pos  (update_pos),
    .bad_pattern (bad_pattern),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the n-th following rising edge.
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Update monitor: counts pulses, checks positions against exp_q, forbids back-to-back pulses.
  always @(negedge clk) begin
    if (!reset && update) begin
      upd_cnt++;
      check("no_back_to_back", 32'(prev_upd), 32'd0);
      if (exp_q.size() > 0) check("update_pos_seq", 32'(update_pos), 32'(exp_q.pop_front()));
    end
    prev_upd = update;
  end

  initial begin
    scan_pat[0] = SEG_A;
    scan_pat[1] = SEG_B;
    scan_pat[2] = SEG_C;
    scan_pat[3] = SEG_D;

    // Reset then idle
    reset = 1'b1;
    an    = 4'b1111;
    segs  = 7'b1111111;
    hold(3);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_update", 32'(update), 32'd0);
    reset = 1'b0;
    upd_cnt = 0;
    hold(100);
    check("idle_updates", 32'(upd_cnt), 32'd0);
    check("idle_digits", 32'(digits), 32'd0);
    check("idle_valid", 32'(digit_valid), 32'd0);
    check("idle_blank", 32'(blank), 32'd0);
    check("idle_bad", 32'(bad_pattern), 32'd0);
    check("idle_pos", 32'(update_pos), 32'd0);

    // Single capture latency: update only in the cycle after E0+5
    upd_cnt = 0;
    an   = 4'b1110;
    segs = SEG_3;
    for (int k = 0; k < 10; k++) begin
      hold(1);
      check("lat_update", 32'(update), (k == 5) ? 32'd1 : 32'd0);
    end
    check("lat_count", 32'(upd_cnt), 32'd1);
    check("lat_pos", 32'(update_pos), 32'd0);
    check("lat_digit0", 32'(digits[3:0]), 32'h3);
    check("lat_valid", 32'(digit_valid), 32'b0001);

    // Full scan A, b, C, d
    upd_cnt = 0;
    for (int p = 0; p < 4; p++) exp_q.push_back(3'(p));
    for (int p = 0; p < 4; p++) begin
      an   = ~(4'b0001 << p);
      segs = scan_pat[p];
      hold(8);
    end
    check("scan_count", 32'(upd_cnt), 32'd4);
    check("scan_q_drained", 32'(exp_q.size()), 32'd0);
    check("scan_digits", 32'(digits), 32'hDCBA);
    check("scan_valid", 32'(digit_valid), 32'b1111);
    check("scan_bad", 32'(bad_pattern), 32'd0);

    // Short glitch on position 1
    an   = 4'b1111;
    hold(6);
    upd_cnt = 0;
    an   = 4'b1101;
    segs = SEG_8;
    hold(3);
    an   = 4'b1111;
    hold(10);
    check("glitch_updates", 32'(upd_cnt), 32'd0);
    check("glitch_digits", 32'(digits), 32'hDCBA);

    // Illegal then blank on position 2
    upd_cnt = 0;
    an   = 4'b1011;
    segs = 7'b1111110;
    hold(10);
    check("illegal_bad", 32'(bad_pattern), 32'd1);
    check("illegal_valid", 32'(digit_valid), 32'b1011);
    check("illegal_digits", 32'(digits), 32'hD0BA);
    check("illegal_blank", 32'(blank), 32'b0000);
    segs = SEG_BLANK;
    hold(10);
    check("blank_blank", 32'(blank), 32'b0100);
    check("blank_bad_sticky", 32'(bad_pattern), 32'd1);
    check("blank_valid", 32'(digit_valid), 32'b1011);
    check("blank_updates", 32'(upd_cnt), 32'd2);

    // Re-strobe of an already captured pattern after an idle gap
    an   = 4'b1111;
    hold(6);
    upd_cnt = 0;
    an   = 4'b1101;
    segs = SEG_B;
    hold(10);
    check("restrobe_updates", 32'(upd_cnt), 32'd1);
    check("restrobe_pos", 32'(update_pos), 32'd1);
    check("restrobe_digits", 32'(digits), 32'hD0BA);

    // Ghosting: two strobes low
    upd_cnt = 0;
    an   = 4'b1100;
    segs = SEG_7;
    hold(20);
    check("ghost_updates", 32'(upd_cnt), 32'd0);
    check("ghost_state", 32'(state_dbg), 32'(ST_IDLE));
    check("ghost_digits", 32'(digits), 32'hD0BA);

    // Reset in the middle of a settle window
    an   = 4'b1110;
    segs = SEG_5;
    hold(3);
    check("mid_state_settle", 32'(state_dbg), 32'(ST_SETTLE));
    reset = 1'b1;
    #1;
    check("mid_rst_digits", 32'(digits), 32'd0);
    check("mid_rst_valid", 32'(digit_valid), 32'd0);
    check("mid_rst_blank", 32'(blank), 32'd0);
    check("mid_rst_bad", 32'(bad_pattern), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    hold(2);
    reset = 1'b0;
    upd_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      hold(1);
      check("post_rst_update", 32'(update), (k == 5) ? 32'd1 : 32'd0);
    end
    check("post_rst_count", 32'(upd_cnt), 32'd1);
    check("post_rst_digits", 32'(digits), 32'h0005);
    check("post_rst_valid", 32'(digit_valid), 32'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
